// File: rtl/bcedn_frame_sched.sv
// Frame scheduler in front of the adapter: issues frame starts, meters pixels
// with an inter-row gap, and retires frames by counting adapter output vectors.
module bcedn_frame_sched #(
  parameter int H                = 32,
  parameter int W                = 128,
  parameter int DATA_IN_FP_WIDTH = 8,
  parameter int ROW_GAP          = 1,
  parameter int OUT_CNT          = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_req,
  output logic                        frame_ack,
  input  logic                        src_valid,
  input  logic [DATA_IN_FP_WIDTH-1:0] src_data,
  output logic                        src_ready,
  output logic                        adp_start,
  output logic                        adp_in_en,
  output logic [DATA_IN_FP_WIDTH-1:0] adp_data,
  input  logic                        adp_tg_next,
  input  logic                        adp_out_en,
  output logic                        frame_done,
  output logic [1:0]                  inflight,
  output logic                        err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int OW = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1;
  localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_CNT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_GAP} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic [OW-1:0]               out_cnt_q, out_cnt_d;
  logic [1:0]                  inflight_q, inflight_d;
  logic                        tg_seen_q, tg_seen_d;
  logic                        err_q, err_d;
  logic                        done_q, done_d;
  logic                        in_en_q;
  logic [DATA_IN_FP_WIDTH-1:0] data_q;
  logic                        launch, start, xfer, out_hit, retire;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_d     = gap_q;
    src_ready = 1'b0;
    start     = 1'b0;
    launch    = 1'b0;
    xfer      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_req && tg_seen_q && (inflight_q != 2'd2)) begin
          launch  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        start   = 1'b1;
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        src_ready = 1'b1;
        xfer      = src_valid;
        if (xfer) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = (ROW_GAP > 0) ? S_GAP : S_STREAM;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // inflight and tg_seen change on the launch edge, so they already reflect
  // the new frame during the START cycle; a tg_next seen during START is dropped.
  always_comb begin
    out_hit   = adp_out_en && (inflight_q != 2'd0);
    retire    = out_hit && (out_cnt_q == OUT_LAST);
    out_cnt_d = out_cnt_q;
    if (retire)       out_cnt_d = '0;
    else if (out_hit) out_cnt_d = out_cnt_q + 1'b1;
    inflight_d = inflight_q;
    unique case ({launch, retire})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
    tg_seen_d = tg_seen_q;
    if (launch)                                tg_seen_d = 1'b0;
    else if (adp_tg_next && state_q != S_START) tg_seen_d = 1'b1;
    err_d  = err_q | (adp_out_en && (inflight_q == 2'd0));
    done_d = retire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      gap_q      <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      tg_seen_q  <= 1'b1;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      in_en_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      gap_q      <= gap_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      tg_seen_q  <= tg_seen_d;
      err_q      <= err_d;
      done_q     <= done_d;
      in_en_q    <= xfer;
      if (xfer) data_q <= src_data;
    end
  end

  assign frame_ack  = start;
  assign adp_start  = start;
  assign adp_in_en  = in_en_q;
  assign adp_data   = data_q;
  assign frame_done = done_q;
  assign inflight   = inflight_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcedn_frame_sched.sv
// Scoreboard bench for bcedn_frame_sched: directed frames, overlap, retire and
// error cases with expected strobes/done pulses queued by cycle.
module tb_bcedn_frame_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_req, frame_ack, src_valid, src_ready;
  logic [7:0] src_data, adp_data;
  logic       adp_start, adp_in_en, adp_tg_next, adp_out_en, frame_done, err;
  logic [1:0] inflight;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct { logic [7:0] d; int c; } px_t;
  px_t px_q[$];
  int  done_q[$];

  bcedn_frame_sched #(.H(2), .W(4), .DATA_IN_FP_WIDTH(8), .ROW_GAP(1), .OUT_CNT(8)) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .frame_ack(frame_ack),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .adp_start(adp_start), .adp_in_en(adp_in_en), .adp_data(adp_data),
    .adp_tg_next(adp_tg_next), .adp_out_en(adp_out_en), .frame_done(frame_done),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe or done pulse.
  always @(negedge clk) begin
    px_t e;
    if (adp_in_en) begin
      if (px_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL px_unexpected: got strobe data %02h at cycle %0d, required none", adp_data, cyc);
      end else begin
        e = px_q.pop_front();
        chk("px_data", adp_data, e.d);
        chk("px_cycle", cyc, e.c);
      end
    end
    if (frame_done) begin
      if (done_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected: got frame_done at cycle %0d, required none", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic send_frame(input logic [7:0] base, input bit toggle);
    int k = 0, gap = 0, other = 0, guard = 0;
    while (k < 8 && guard < 60) begin
      @(negedge clk);
      guard++;
      src_valid = toggle ? guard[0] : 1'b1;
      src_data  = base + 8'(k);
      if (!src_ready) begin
        if (k == 4) gap++;
        else other++;
      end else if (src_valid) begin
        px_q.push_back('{d: base + 8'(k), c: cyc + 1});
        k++;
      end
    end
    @(negedge clk);
    src_valid = 1'b0;
    chk("xfer_count", k, 8);
    chk("gap_after_row0", gap, 1);
    chk("ready_low_elsewhere", other, 0);
    chk("ready_low_after_frame", src_ready, 0);
  endtask

  task automatic wait_ack(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_ack && t < 20);
    chk(name, frame_ack, 1);
    chk("start_with_ack", adp_start, 1);
  endtask

  task automatic pulse_out(input int n, input int done_at);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      adp_out_en = 1'b1;
      if (i == done_at) done_q.push_back(cyc + 1);
    end
    @(negedge clk);
    adp_out_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; frame_req = 1'b1; src_valid = 1'b1; src_data = 8'hAA;
    adp_tg_next = 1'b0; adp_out_en = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_outputs", {frame_ack, adp_start, adp_in_en, adp_data, src_ready,
                            frame_done, inflight, err}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("first_ack", frame_ack, 1);
    chk("first_start", adp_start, 1);
    chk("first_inflight", inflight, 1);
    frame_req = 1'b0;
    send_frame(8'h01, 1'b0);

    chk("pre_retire_inflight", inflight, 1);
    pulse_out(8, 8);
    chk("retire0_inflight", inflight, 0);

    // Frame A: started by a fresh tg_next, pixels with toggling valid.
    @(negedge clk); frame_req = 1'b1; adp_tg_next = 1'b1;
    @(negedge clk); adp_tg_next = 1'b0;
    wait_ack("ack_A");
    chk("inflight_A", inflight, 1);
    frame_req = 1'b0;
    send_frame(8'h11, 1'b1);

    // Frame B overlaps A's drain.
    pulse_out(3, 0);
    frame_req = 1'b1; adp_tg_next = 1'b1;
    @(negedge clk); adp_tg_next = 1'b0;
    wait_ack("ack_B");
    chk("inflight_B", inflight, 2);
    frame_req = 1'b0;
    send_frame(8'h21, 1'b0);

    // Third request withheld while two frames are in flight.
    frame_req = 1'b1; adp_tg_next = 1'b1;
    @(negedge clk); adp_tg_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("third_withheld", {frame_ack, inflight}, {1'b0, 2'd2});
    end
    frame_req = 1'b0;
    pulse_out(5, 5);
    chk("retire_A_inflight", inflight, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("withdrawn_no_start", frame_ack, 0);
    end

    // Retire B and launch C on the same edge.
    pulse_out(7, 0);
    adp_out_en = 1'b1; frame_req = 1'b1;
    done_q.push_back(cyc + 1);
    @(negedge clk);
    adp_out_en = 1'b0;
    chk("ack_C_coincident", frame_ack, 1);
    chk("inflight_net_zero", inflight, 1);
    frame_req = 1'b0;
    send_frame(8'h31, 1'b0);
    pulse_out(8, 8);
    chk("retire_C_inflight", inflight, 0);

    // Stray out_en with nothing in flight.
    pulse_out(1, 0);
    chk("err_set", err, 1);
    chk("err_inflight", inflight, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", err, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("px_queue_empty", px_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
